// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one serial sender among NUM_REQ byte sources. One byte is accepted at
// a time over a valid/ready handshake, handed to the sender via tx_data/tx_en,
// tracked through the sender idle flag, and followed by an enforced idle gap.
//
// Parameters:
//   NUM_REQ        number of requesters (2..8)
//   GAP_CYCLES     idle clk cycles after the sender returns idle (0..65535)
//   START_TIMEOUT  clk cycles allowed for the sender to leave idle (1..65535)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_data     in   requester i byte at [8i+7:8i]
//   req_valid    in   requester i holds a byte (data stable while high)
//   req_ready    out  combinational one-hot accept
//   tx_status    in   sender idle flag (1 = idle)
//   tx_data      out  registered byte to the sender
//   tx_en        out  registered start request to the sender
//   grant        out  registered one-hot owner of the frame in flight
//   busy         out  high whenever the FSM is not idle
//   timeout_err  out  one-cycle pulse when a start times out
//
// Configuration macro:
//   UART_TX_ARB_FIXED_PRIO_EN  defined: lowest-index valid requester always
//                              wins and no rotation pointer is built.
//                              undefined: round-robin arbitration.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 20000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_status,
    output logic [7:0]           tx_data,
    output logic                 tx_en,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int SUM_W   = IDX_W + 1;
    localparam int TMAX    = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int TIMER_W = $clog2(TMAX + 1);

    localparam logic [TIMER_W-1:0] START_LOAD = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES);
    localparam logic [SUM_W-1:0]   NUM_REQ_S  = SUM_W'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0   = NUM_REQ'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [TIMER_W-1:0]   timer_r, timer_nxt_s;
    logic [7:0]           tx_data_r, tx_data_nxt_s;
    logic                 tx_en_r, tx_en_nxt_s;
    logic [NUM_REQ-1:0]   grant_r, grant_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 timeout_err_r, timeout_err_nxt_s;

    logic [IDX_W-1:0]     ptr_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic                 found_s;
    logic [IDX_W-1:0]     winner_s;
    logic [SUM_W-1:0]     sum_s;
    logic [7:0]           sel_data_s;
    logic                 accept_s;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // Search always starts at requester 0, so the lowest valid index wins.
    assign ptr_s = '0;
`else
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] next_ptr_s;
    logic [SUM_W-1:0] inc_s;

    // Pointer moves to the requester just after the one accepted.
    always_comb begin
        inc_s = {1'b0, winner_s} + SUM_W'(1'b1);
        if (inc_s >= NUM_REQ_S) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = inc_s[IDX_W-1:0];
        end
    end

    // Round-robin pointer register, only updated on an actual transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (accept_s) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`endif

    // Rotate the valid vector so bit 0 is the requester at the pointer;
    // a plain upward scan of rot_s then implements the wrapping search.
    assign rot_s = NUM_REQ'({req_valid, req_valid} >> ptr_s);

    // First set bit of the rotated vector, mapped back to a requester index.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        sum_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && rot_s[i]) begin
                found_s = 1'b1;
                sum_s   = {1'b0, ptr_s} + SUM_W'(i);
                if (sum_s >= NUM_REQ_S) begin
                    sum_s = sum_s - NUM_REQ_S;
                end else begin
                    sum_s = sum_s;
                end
                winner_s = sum_s[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Byte lane of the arbitration winner.
    always_comb begin
        sel_data_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_s == IDX_W'(i)) begin
                sel_data_s = req_data[8*i +: 8];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Accept only while idle and the sender itself reports idle.
    assign accept_s  = (state_r == ST_IDLE) && tx_status && found_s;
    assign req_ready = accept_s ? (ONE_HOT0 << winner_s) : '0;

    // Next-state and next-output logic of the frame FSM.
    always_comb begin
        state_nxt_s       = state_r;
        timer_nxt_s       = timer_r;
        tx_data_nxt_s     = tx_data_r;
        tx_en_nxt_s       = tx_en_r;
        grant_nxt_s       = grant_r;
        timeout_err_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    tx_data_nxt_s = sel_data_s;
                    grant_nxt_s   = ONE_HOT0 << winner_s;
                    tx_en_nxt_s   = 1'b1;
                    timer_nxt_s   = START_LOAD;
                    state_nxt_s   = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (!tx_status) begin
                    tx_en_nxt_s = 1'b0;
                    state_nxt_s = ST_SEND;
                end else if (timer_r == '0) begin
                    // Sender never left idle: drop the byte, no retry.
                    tx_en_nxt_s       = 1'b0;
                    timeout_err_nxt_s = 1'b1;
                    grant_nxt_s       = '0;
                    timer_nxt_s       = GAP_LOAD;
                    state_nxt_s       = ST_GAP;
                end else begin
                    timer_nxt_s = timer_r - TIMER_W'(1'b1);
                end
            end
            ST_SEND: begin
                if (tx_status) begin
                    grant_nxt_s = '0;
                    timer_nxt_s = GAP_LOAD;
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (timer_r == '0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    timer_nxt_s = timer_r - TIMER_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                tx_en_nxt_s = 1'b0;
                grant_nxt_s = '0;
                timer_nxt_s = '0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            timer_r       <= '0;
            tx_data_r     <= 8'h00;
            tx_en_r       <= 1'b0;
            grant_r       <= '0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            timer_r       <= timer_nxt_s;
            tx_data_r     <= tx_data_nxt_s;
            tx_en_r       <= tx_en_nxt_s;
            grant_r       <= grant_nxt_s;
            busy_r        <= busy_nxt_s;
            timeout_err_r <= timeout_err_nxt_s;
        end
    end

    assign tx_data     = tx_data_r;
    assign tx_en       = tx_en_r;
    assign grant       = grant_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one serial `sender` among `NUM_REQ` byte sources. It accepts a byte from one requester at a time over a valid/ready handshake. It drives the sender's `tx_data`/`tx_en`, tracks the frame through the sender's `tx_status` (1 = idle), and enforces a minimum inter-frame gap. It sits between the application byte sources and `sender` in the serial transceiver top level, on the system clock.

## Interface
- `NUM_REQ`, 2: number of requesters, legal 2..8.
- `GAP_CYCLES`, 16: idle `clk` cycles enforced after the sender returns idle, legal 0..65535.
- `START_TIMEOUT`, 20000: `clk` cycles allowed for the sender to leave idle after `tx_en`, legal 1..65535; must exceed the send-clock divide ratio.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_data`  in  8*NUM_REQ  requester i byte at [8i+7:8i].
- `req_valid`  in  NUM_REQ  requester i holds a byte; data stable while high.
- `req_ready`  out  NUM_REQ  combinational one-hot accept; transfer when valid&ready in the same cycle.
- `tx_status`  in  1  sender idle flag (1 = idle).
- `tx_data`  out  8  registered byte to sender.
- `tx_en`  out  1  registered start request to sender.
- `grant`  out  NUM_REQ  registered one-hot owner of the frame in flight.
- `busy`  out  1  high whenever state ≠ IDLE.
- `timeout_err`  out  1  one-cycle pulse when a start times out.

## Operation
- FSM states: IDLE, START, SEND, GAP. A single down-counter `timer` is shared by START and GAP. Its width is clog2(max(START_TIMEOUT, GAP_CYCLES)+1).
- IDLE: `req_ready[w]` = (state==IDLE) & `tx_status` & winner==w, where `w` is the arbitration winner among the set `req_valid` bits.
  - On transfer: latch `tx_data` ← byte w, `grant` ← onehot(w), `tx_en` ← 1, `timer` ← START_TIMEOUT-1, advance the pointer to w+1 mod NUM_REQ, go to START.
  - With no valid request or `tx_status`=0, stay in IDLE with all `req_ready` low.
- START: hold `tx_en`=1.
  - If `tx_status`=0: `tx_en` ← 0, go to SEND.
  - Else if `timer`==0: `tx_en` ← 0, pulse `timeout_err`, clear `grant`, load the gap, go to GAP. The byte is dropped and not retried.
  - Else decrement `timer`.
- SEND: wait for `tx_status`=1, then clear `grant`, go to GAP with `timer` ← GAP_CYCLES.
- GAP: if `timer`==0 go to IDLE, else decrement. With GAP_CYCLES=0, GAP lasts exactly one cycle.
- Round-robin arbitration: search `req_valid` upward from the pointer, wrapping. The first set bit wins.
- Simultaneous valids: exactly one is granted. Others stay pending with `req_ready` low.
- A requester dropping `req_valid` before acceptance loses its turn without side effects.
- `tx_data` is held unchanged after the frame until the next acceptance.

## Timing
- Reset (async assert, sync-released by the top level): state IDLE, `tx_en`=0, `tx_data`=0, `grant`=0, pointer=0, `timer`=0, `timeout_err`=0, `busy`=0.
- Reset mid-frame aborts immediately. `tx_en` drops asynchronously, and the sender's in-progress frame is not tracked afterwards.
- Latency:
  - `req_valid` rises in cycle n while IDLE and `tx_status`=1: `req_ready` is high in cycle n.
  - `tx_en`, `grant` and `busy` are high in cycle n+1.
- Minimum spacing between two acceptances: START ≥1 + SEND ≥1 + GAP GAP_CYCLES+1 cycles.
- `timeout_err` rises exactly START_TIMEOUT cycles after `tx_en` rises if `tx_status` never falls.

## Configuration
- `UART_TX_ARB_FIXED_PRIO_EN` defined: fixed priority. The lowest-index valid requester always wins, and the pointer register is not built.
- Undefined: round-robin as specified above.

## Test plan
- Single byte: `req_valid[0]`=1, data 0x41, `tx_status`=1 → `req_ready[0]` pulses one cycle; next cycle `tx_en`=1, `tx_data`=0x41, `grant`=01. Model drops `tx_status` after 5 cycles → `tx_en`=0 the cycle after. Raise `tx_status` → GAP of 17 cycles, then IDLE.
- Contention (round-robin, NUM_REQ=2): both valid continuously with 0xAA/0x55 → grants alternate 01,10,01,10 and the sender receives AA,55,AA,55. With `UART_TX_ARB_FIXED_PRIO_EN` → the sender receives only 0xAA.
- Timeout: START_TIMEOUT=8, `tx_status` held 1 → `tx_en` high exactly 8 cycles, `timeout_err` pulses once, `grant` clears, state returns to IDLE after the gap.
- Sender busy: `tx_status`=0 with `req_valid`=1 → `req_ready` stays 0 and no `tx_en`. Release `tx_status` → accept in the same cycle.
- Reset mid-SEND: assert `rst_n`=0 → all outputs 0 immediately. After release, pointer=0, so requester 0 wins first.
- GAP_CYCLES=0: back-to-back frames → the next `req_ready` arrives 2 cycles after `tx_status` returns to 1.
